wb_cache_ctrl: RTL and testbench
================================

Name: wb_cache_ctrl

Overview:
Parametrised write-back cache controller FSM, the successor to the single-beat controller. It adds multi-beat line refill and write-back over a ready/valid memory port, and a hardware flush walker that visits every line and writes back only valid+dirty lines. It also keeps saturating hit/miss statistics. It sits between the CPU load/store path, the tag/data arrays and the main-memory interface.

Parameters:
NUM_LINES, 64, number of cache lines walked by flush; power of two, >=2
BEATS, 4, memory beats per line; power of two, >=2
CNT_W, 16, width of hit/miss statistic counters
(derived) IDX_W = $clog2(NUM_LINES), BEAT_W = $clog2(BEATS)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request, held until stall low
cpu_we  in  1  request is a store
hit  in  1  tag match for current CPU address (combinational from tag array)
dirty  in  1  dirty bit of addressed line (CPU line in normal mode, flush_idx line during flush)
line_valid  in  1  valid bit of addressed line (same addressing as dirty)
flush_req  in  1  flush command (fence); single-cycle pulse allowed
mem_ready  in  1  memory accepts current request/write beat
mem_rsp_valid  in  1  memory returns a refill beat
stall  out  1  CPU must hold request
cache_en  out  1  data array serves CPU access this cycle
set_dirty  out  1  mark CPU line dirty (store hit)
mem_rd_req  out  1  refill address request
mem_wr_req  out  1  write-back beat valid
beat_idx  out  BEAT_W  current beat within line
line_wr_en  out  1  write refill beat into data array
tag_update  out  1  install new tag, valid=1, dirty=0
clr_dirty  out  1  clear dirty of flush_idx line
inv_en  out  1  invalidate flush_idx line
flush_mode  out  1  arrays addressed by flush_idx
flush_idx  out  IDX_W  line under flush
flush_done  out  1  one-cycle pulse at flush completion
hit_cnt  out  CNT_W  saturating hit count
miss_cnt  out  CNT_W  saturating miss count

Behaviour:
- Reset (async, any state): state=IDLE, beat_cnt=0, flush_idx=0, flush_pending=0, hit_cnt=miss_cnt=0; all outputs 0. In-flight memory transactions are abandoned; the memory side is reset together with this block.
- States: IDLE, WB, RD_REQ, REFILL, F_CHK, F_WB, F_NEXT.
- IDLE, cpu_req&hit: cache_en=1, stall=0, set_dirty=cpu_we, hit_cnt+1. Zero-latency hit.
- IDLE, cpu_req&~hit: stall=1 same cycle, miss_cnt+1; next WB if line_valid&dirty, else RD_REQ.
- IDLE, ~cpu_req & (flush_req|flush_pending): enter F_CHK with flush_idx=0, flush_pending=0.
- cpu_req and flush_req in the same IDLE cycle: CPU wins; flush_pending latches and is served at the first IDLE cycle without cpu_req.
- flush_req arriving outside IDLE sets flush_pending.
- WB / F_WB: mem_wr_req=1, beat_idx=beat_cnt. A beat transfers on mem_wr_req&mem_ready, and beat_cnt increments on transfer. On the transfer of beat BEATS-1, beat_cnt wraps to 0. WB then goes to RD_REQ. F_WB asserts clr_dirty and inv_en for one cycle and goes to F_NEXT.
- RD_REQ: mem_rd_req=1 until mem_ready, then REFILL.
- REFILL: each mem_rsp_valid cycle gives line_wr_en=1, beat_idx=beat_cnt, beat_cnt+1. On the last beat, tag_update=1, beat_cnt wraps to 0, and the next state is IDLE; the retried request then hits.
- Minimum clean-miss penalty is 2+BEATS cycles.
- F_CHK: flush_mode=1. If line_valid&dirty go to F_WB. Else if line_valid, inv_en=1 and go to F_NEXT. Otherwise go to F_NEXT.
- F_NEXT: if flush_idx==NUM_LINES-1, flush_done=1, flush_idx wraps to 0, go to IDLE. Else flush_idx+1, go to F_CHK.
- flush_mode=1 in F_CHK, F_WB and F_NEXT.
- stall = cpu_req & (state!=IDLE | ~hit).
- Counters saturate at 2^CNT_W-1; they do not wrap.
- mem_ready or mem_rsp_valid in states that do not expect them are ignored.

Decomposition:
- Package cache_ctrl_pkg: state enum (3-bit), default parameter constants, and a clog2-safe width function.
- One sub-module, sat_counter (CNT_W, inc, value), instantiated twice for the statistics.
- The beat counter and flush index stay inline.

Test Plan:
- Reset asserted mid-REFILL at beat 2 -> next cycle all outputs 0, state IDLE, beat_idx=0; counters 0.
- BEATS=4: load hit, then store hit -> cache_en=1, stall=0 both cycles; set_dirty=1 only on store; hit_cnt=2.
- Clean miss, mem_ready on cycle 1, rsp_valid on 4 consecutive cycles -> line_wr_en with beat_idx 0,1,2,3, tag_update on beat 3, stall high 6 cycles, miss_cnt=1.
- Dirty miss with mem_ready low 2 cycles per beat -> 4 write beats with beat_idx 0..3, each held until ready; then RD_REQ and refill; beat_idx restarts at 0.
- NUM_LINES=8, lines 2 and 5 valid+dirty, line 3 valid clean -> write beats only for idx 2 and 5; inv_en for idx 2, 3, 5; flush_done pulse once after idx 7; flush_idx returns to 0.
- flush_req and cpu_req miss in the same cycle -> miss serviced first, flush starts in the first following IDLE cycle without cpu_req; hit_cnt forced to saturation stays at 0xFFFF.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cache_ctrl_pkg
// Shared types and constants for the write-back cache controller:
//   - state_e     : controller FSM state encoding (3 bits)
//   - DEF_*       : default parameter values for wb_cache_ctrl
//   - safe_clog2  : index width helper that never returns 0
// ----------------------------------------------------------------------------
package cache_ctrl_pkg;

    localparam int DEF_NUM_LINES = 64;
    localparam int DEF_BEATS     = 4;
    localparam int DEF_CNT_W     = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WB     = 3'd1,
        S_RD_REQ = 3'd2,
        S_REFILL = 3'd3,
        S_F_CHK  = 3'd4,
        S_F_WB   = 3'd5,
        S_F_NEXT = 3'd6
    } state_e;

    // Width of a counter/index covering 0..n-1; a 1-bit minimum keeps vector
    // declarations legal for the degenerate n<=2 cases.
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the hit/miss statistics. Sticks at all-ones
// instead of wrapping.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset, clears the count
//   inc    in   increment request for this cycle
//   value  out  current count (CNT_W bits)
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    logic [CNT_W-1:0] value_q;
    logic [CNT_W-1:0] value_d;

    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        value_d = value_q;
        if (inc && (value_q != '1)) begin
            value_d = value_q + 1'b1;
        end
    end

    // NOTE: flops use non-blocking assignments so all registers update
    // together at the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/wb_cache_ctrl.sv
// ----------------------------------------------------------------------------
// wb_cache_ctrl
// Write-back cache controller FSM. Serves zero-latency hits, handles misses by
// writing back a dirty victim (BEATS beats) and refilling the line (BEATS
// beats) over a ready/valid memory port, and runs a flush walker that visits
// every line, writing back valid+dirty lines and invalidating valid ones.
// Keeps saturating hit/miss statistics.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cpu_req, cpu_we   CPU access request (held while stalled), store flag
//   hit               tag match for the CPU address
//   dirty, line_valid state bits of the addressed line (CPU line, or the
//                     flush_idx line while flush_mode=1)
//   flush_req         flush command; a one-cycle pulse is enough
//   mem_ready         memory accepts the read request / current write beat
//   mem_rsp_valid     memory returns a refill beat
//   stall             CPU must hold its request
//   cache_en          data array serves the CPU access this cycle
//   set_dirty         mark the CPU line dirty (store hit)
//   mem_rd_req        refill address request
//   mem_wr_req        write-back beat valid
//   beat_idx          beat within the line being moved
//   line_wr_en        write refill beat into the data array
//   tag_update        install new tag, valid=1, dirty=0
//   clr_dirty, inv_en clear dirty / invalidate the flush_idx line
//   flush_mode        arrays are addressed by flush_idx
//   flush_idx         line under flush
//   flush_done        one-cycle pulse when the walk completes
//   hit_cnt, miss_cnt saturating statistics
// ----------------------------------------------------------------------------
module wb_cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter  int NUM_LINES = DEF_NUM_LINES,
    parameter  int BEATS     = DEF_BEATS,
    parameter  int CNT_W     = DEF_CNT_W,
    localparam int IDX_W     = safe_clog2(NUM_LINES),
    localparam int BEAT_W    = safe_clog2(BEATS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              hit,
    input  logic              dirty,
    input  logic              line_valid,
    input  logic              flush_req,
    input  logic              mem_ready,
    input  logic              mem_rsp_valid,
    output logic              stall,
    output logic              cache_en,
    output logic              set_dirty,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              line_wr_en,
    output logic              tag_update,
    output logic              clr_dirty,
    output logic              inv_en,
    output logic              flush_mode,
    output logic [IDX_W-1:0]  flush_idx,
    output logic              flush_done,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_LINES - 1);

    state_e            state_q,         state_d;
    logic [BEAT_W-1:0] beat_cnt_q,      beat_cnt_d;
    logic [IDX_W-1:0]  flush_idx_q,     flush_idx_d;
    logic              flush_pending_q, flush_pending_d;
    logic              hit_inc;
    logic              miss_inc;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: the reset clears only control state; the tag/data arrays live
    // outside this block and are never reset here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            beat_cnt_q      <= '0;
            flush_idx_q     <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            beat_cnt_q      <= beat_cnt_d;
            flush_idx_q     <= flush_idx_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        flush_idx_d = flush_idx_q;
        // Any flush command is remembered; only the IDLE flush entry clears it.
        flush_pending_d = flush_pending_q | flush_req;

        cache_en   = 1'b0;
        set_dirty  = 1'b0;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        beat_idx   = '0;
        line_wr_en = 1'b0;
        tag_update = 1'b0;
        clr_dirty  = 1'b0;
        inv_en     = 1'b0;
        flush_mode = 1'b0;
        flush_done = 1'b0;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // A CPU request always wins over a flush in the same cycle.
                if (cpu_req) begin
                    if (hit) begin
                        cache_en  = 1'b1;
                        set_dirty = cpu_we;
                        hit_inc   = 1'b1;
                    end else begin
                        miss_inc = 1'b1;
                        state_d  = (line_valid && dirty) ? S_WB : S_RD_REQ;
                    end
                end else if (flush_req || flush_pending_q) begin
                    state_d         = S_F_CHK;
                    flush_idx_d     = '0;
                    flush_pending_d = 1'b0;
                end
            end

            S_WB, S_F_WB: begin
                mem_wr_req = 1'b1;
                beat_idx   = beat_cnt_q;
                flush_mode = (state_q == S_F_WB);
                if (mem_ready) begin
                    // Power-of-two BEATS: the increment wraps to 0 after the
                    // last beat on its own.
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        if (state_q == S_F_WB) begin
                            clr_dirty = 1'b1;
                            inv_en    = 1'b1;
                            state_d   = S_F_NEXT;
                        end else begin
                            state_d = S_RD_REQ;
                        end
                    end
                end
            end

            S_RD_REQ: begin
                mem_rd_req = 1'b1;
                if (mem_ready) begin
                    state_d = S_REFILL;
                end
            end

            S_REFILL: begin
                beat_idx = beat_cnt_q;
                if (mem_rsp_valid) begin
                    line_wr_en = 1'b1;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        tag_update = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end

            S_F_CHK: begin
                flush_mode = 1'b1;
                if (line_valid && dirty) begin
                    state_d = S_F_WB;
                end else begin
                    inv_en  = line_valid;
                    state_d = S_F_NEXT;
                end
            end

            S_F_NEXT: begin
                flush_mode = 1'b1;
                if (flush_idx_q == LAST_IDX) begin
                    flush_done  = 1'b1;
                    flush_idx_d = '0;
                    state_d     = S_IDLE;
                end else begin
                    flush_idx_d = flush_idx_q + 1'b1;
                    state_d     = S_F_CHK;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign stall     = cpu_req && ((state_q != S_IDLE) || !hit);
    assign flush_idx = flush_idx_q;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .value (hit_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc),
        .value (miss_cnt)
    );

endmodule

// File: tb/tb_wb_cache_ctrl.sv
// ----------------------------------------------------------------------------
// tb_wb_cache_ctrl
// Self-checking bench for wb_cache_ctrl (NUM_LINES=8, BEATS=4, CNT_W=16).
// Expected memory-side events (write beats, refill beats, invalidates) are
// queued when stimulus is applied and matched as the DUT produces them.
// ----------------------------------------------------------------------------
module tb_wb_cache_ctrl;

    localparam int NL    = 8;
    localparam int BT    = 4;
    localparam int CW    = 16;
    localparam int IW    = 3;
    localparam int BW    = 2;
    localparam int OUT_W = 11 + BW + IW + 2 * CW;

    logic          clk;
    logic          rst;
    logic          cpu_req, cpu_we, hit, dirty, line_valid, flush_req;
    logic          mem_ready, mem_rsp_valid;
    logic          stall, cache_en, set_dirty, mem_rd_req, mem_wr_req;
    logic [BW-1:0] beat_idx;
    logic          line_wr_en, tag_update, clr_dirty, inv_en, flush_mode;
    logic [IW-1:0] flush_idx;
    logic          flush_done;
    logic [CW-1:0] hit_cnt, miss_cnt;
    logic [OUT_W-1:0] outs;

    wb_cache_ctrl #(.NUM_LINES(NL), .BEATS(BT), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .hit           (hit),
        .dirty         (dirty),
        .line_valid    (line_valid),
        .flush_req     (flush_req),
        .mem_ready     (mem_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .stall         (stall),
        .cache_en      (cache_en),
        .set_dirty     (set_dirty),
        .mem_rd_req    (mem_rd_req),
        .mem_wr_req    (mem_wr_req),
        .beat_idx      (beat_idx),
        .line_wr_en    (line_wr_en),
        .tag_update    (tag_update),
        .clr_dirty     (clr_dirty),
        .inv_en        (inv_en),
        .flush_mode    (flush_mode),
        .flush_idx     (flush_idx),
        .flush_done    (flush_done),
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt)
    );

    assign outs = {stall, cache_en, set_dirty, mem_rd_req, mem_wr_req, beat_idx,
                   line_wr_en, tag_update, clr_dirty, inv_en, flush_mode,
                   flush_idx, flush_done, hit_cnt, miss_cnt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {EV_WR, EV_RFL, EV_INV} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       idx;
        int       beat;
    } ev_t;

    ev_t sb_q[$];
    int  n_vec;
    int  n_err;
    int  exp_hit;
    int  exp_miss;
    bit  lv[NL];
    bit  ld[NL];

    task automatic sb_push(input ev_kind_e k, input int idx, input int beat);
        ev_t e;
        e.kind = k;
        e.idx  = idx;
        e.beat = beat;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input ev_kind_e k, input int idx, input int beat);
        ev_t e;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_%s: got idx=%0d beat=%0d, expected no event", k.name(), idx, beat);
        end else begin
            e = sb_q.pop_front();
            if (e.kind !== k || e.idx !== idx || e.beat !== beat) begin
                n_err++;
                $display("FAIL sb_event: got %s idx=%0d beat=%0d, expected %s idx=%0d beat=%0d",
                         k.name(), idx, beat, e.kind.name(), e.idx, e.beat);
            end
        end
    endtask

    // Match memory-side events seen this cycle, then advance to just after
    // the next rising edge.
    task automatic next_cycle();
        if (mem_wr_req && mem_ready) sb_pop(EV_WR, int'(flush_idx), int'(beat_idx));
        if (line_wr_en)              sb_pop(EV_RFL, int'(flush_idx), int'(beat_idx));
        if (inv_en)                  sb_pop(EV_INV, int'(flush_idx), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_sb_empty(input string name);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d events outstanding, expected 0", name, sb_q.size());
        end
    endtask

    task automatic check_counters(input string name);
        n_vec++;
        if (hit_cnt !== CW'(exp_hit) || miss_cnt !== CW'(miss_cnt_exp())) begin
            n_err++;
            $display("FAIL %s: hit_cnt=%0d miss_cnt=%0d, expected %0d %0d",
                     name, hit_cnt, miss_cnt, exp_hit, exp_miss);
        end
    endtask

    function automatic int miss_cnt_exp();
        return exp_miss;
    endfunction

    // Walk with the bench line model answering line_valid/dirty for flush_idx.
    // A flush_req pulse is applied on cycle pulse_at (-1 for none).
    task automatic run_flush(input int pulse_at, output bit done, output int clrs);
        int cyc;
        done = 1'b0;
        clrs = 0;
        cyc  = 0;
        while (!done && cyc < 300) begin
            flush_req  = (cyc == pulse_at);
            line_valid = lv[flush_idx];
            dirty      = ld[flush_idx];
            mem_ready  = 1'($urandom_range(0, 1));
            #1;
            n_vec++;
            if (flush_mode !== 1'b1) begin
                n_err++;
                $display("FAIL flush_mode_walk: flush_mode=%b at cycle %0d, expected 1", flush_mode, cyc);
            end
            if (clr_dirty) begin
                clrs++;
                ld[flush_idx] = 1'b0;
            end
            if (inv_en) lv[flush_idx] = 1'b0;
            if (flush_done) begin
                done = 1'b1;
                n_vec++;
                if (flush_idx !== IW'(NL - 1)) begin
                    n_err++;
                    $display("FAIL flush_done_idx: flush_idx=%0d, expected %0d", flush_idx, NL - 1);
                end
            end
            next_cycle();
            cyc++;
        end
        flush_req  = 1'b0;
        mem_ready  = 1'b0;
        line_valid = 1'b0;
        dirty      = 1'b0;
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL flush_timeout: flush_done=0 after %0d cycles, expected pulse", cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; hit = 0; dirty = 0; line_valid = 0;
        flush_req = 0; mem_ready = 0; mem_rsp_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (outs !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: outs=%h, expected 0", outs);
        end
        rst = 1'b0;
        exp_hit  = 0;
        exp_miss = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_hits();
        cpu_req = 1; hit = 1; cpu_we = 0;
        #1;
        n_vec++;
        if ({cache_en, stall, set_dirty} !== 3'b100) begin
            n_err++;
            $display("FAIL load_hit: en/stall/set_dirty=%b, expected 100", {cache_en, stall, set_dirty});
        end
        exp_hit++;
        next_cycle();
        cpu_we = 1;
        #1;
        n_vec++;
        if ({cache_en, stall, set_dirty} !== 3'b101) begin
            n_err++;
            $display("FAIL store_hit: en/stall/set_dirty=%b, expected 101", {cache_en, stall, set_dirty});
        end
        exp_hit++;
        next_cycle();
        cpu_req = 0; cpu_we = 0; hit = 0;
        #1;
        check_counters("hit_counts");
    endtask

    task automatic test_clean_miss();
        int stalls;
        stalls = 0;
        cpu_req = 1; hit = 0; line_valid = 0; dirty = 0;
        for (int b = 0; b < BT; b++) sb_push(EV_RFL, 0, b);
        #1;
        n_vec++;
        if (stall !== 1'b1 || mem_wr_req !== 1'b0 || cache_en !== 1'b0) begin
            n_err++;
            $display("FAIL clean_miss_idle: stall=%b wr=%b en=%b, expected 1 0 0", stall, mem_wr_req, cache_en);
        end
        stalls += int'(stall);
        exp_miss++;
        next_cycle();
        mem_ready = 1;
        #1;
        n_vec++;
        if (mem_rd_req !== 1'b1) begin
            n_err++;
            $display("FAIL clean_miss_rdreq: mem_rd_req=%b, expected 1", mem_rd_req);
        end
        stalls += int'(stall);
        next_cycle();
        mem_ready = 0;
        for (int b = 0; b < BT; b++) begin
            mem_rsp_valid = 1;
            #1;
            n_vec++;
            if ({line_wr_en, tag_update} !== {1'b1, (b == BT - 1)}) begin
                n_err++;
                $display("FAIL clean_miss_refill: beat %0d wr_en/tag=%b, expected %b",
                         b, {line_wr_en, tag_update}, {1'b1, (b == BT - 1)});
            end
            stalls += int'(stall);
            next_cycle();
        end
        mem_rsp_valid = 0;
        hit = 1;
        #1;
        n_vec++;
        if ({stall, cache_en} !== 2'b01) begin
            n_err++;
            $display("FAIL clean_miss_retry: stall/en=%b, expected 01", {stall, cache_en});
        end
        exp_hit++;
        next_cycle();
        n_vec++;
        if (stalls != 2 + BT) begin
            n_err++;
            $display("FAIL clean_miss_penalty: %0d stall cycles, expected %0d", stalls, 2 + BT);
        end
        cpu_req = 0; hit = 0;
        #1;
        check_counters("clean_miss_counts");
        check_sb_empty("clean_miss_sb");
    endtask

    task automatic test_dirty_miss();
        cpu_req = 1; hit = 0; line_valid = 1; dirty = 1;
        for (int b = 0; b < BT; b++) sb_push(EV_WR, 0, b);
        for (int b = 0; b < BT; b++) sb_push(EV_RFL, 0, b);
        #1;
        n_vec++;
        if (stall !== 1'b1 || mem_rd_req !== 1'b0) begin
            n_err++;
            $display("FAIL dirty_miss_idle: stall=%b rd=%b, expected 1 0", stall, mem_rd_req);
        end
        exp_miss++;
        next_cycle();
        line_valid = 0; dirty = 0;
        for (int b = 0; b < BT; b++) begin
            for (int w = 0; w < 3; w++) begin
                mem_ready = (w == 2);
                #1;
                n_vec++;
                if (mem_wr_req !== 1'b1 || beat_idx !== BW'(b)) begin
                    n_err++;
                    $display("FAIL dirty_miss_wb: wr=%b beat_idx=%0d, expected 1 %0d", mem_wr_req, beat_idx, b);
                end
                next_cycle();
            end
        end
        mem_ready = 0;
        #1;
        n_vec++;
        if (mem_rd_req !== 1'b1 || mem_wr_req !== 1'b0) begin
            n_err++;
            $display("FAIL dirty_miss_rdreq: rd=%b wr=%b, expected 1 0", mem_rd_req, mem_wr_req);
        end
        next_cycle();
        mem_ready = 1;
        #1;
        next_cycle();
        mem_ready = 0;
        for (int b = 0; b < BT; b++) begin
            if (b == 2) begin
                mem_rsp_valid = 0;
                #1;
                n_vec++;
                if (line_wr_en !== 1'b0 || stall !== 1'b1) begin
                    n_err++;
                    $display("FAIL dirty_miss_gap: wr_en=%b stall=%b, expected 0 1", line_wr_en, stall);
                end
                next_cycle();
            end
            mem_rsp_valid = 1;
            #1;
            n_vec++;
            if (line_wr_en !== 1'b1 || beat_idx !== BW'(b)) begin
                n_err++;
                $display("FAIL dirty_miss_refill: wr_en=%b beat_idx=%0d, expected 1 %0d", line_wr_en, beat_idx, b);
            end
            next_cycle();
        end
        mem_rsp_valid = 0;
        hit = 1;
        #1;
        n_vec++;
        if (cache_en !== 1'b1) begin
            n_err++;
            $display("FAIL dirty_miss_retry: cache_en=%b, expected 1", cache_en);
        end
        exp_hit++;
        next_cycle();
        cpu_req = 0; hit = 0;
        #1;
        check_counters("dirty_miss_counts");
        check_sb_empty("dirty_miss_sb");
    endtask

    task automatic test_flush();
        bit done;
        int clrs;
        int pulses;
        for (int i = 0; i < NL; i++) begin
            lv[i] = 0;
            ld[i] = 0;
        end
        lv[2] = 1; ld[2] = 1;
        lv[3] = 1;
        lv[5] = 1; ld[5] = 1;
        for (int i = 0; i < NL; i++) begin
            if (lv[i] && ld[i]) begin
                for (int b = 0; b < BT; b++) sb_push(EV_WR, i, b);
                sb_push(EV_INV, i, 0);
            end else if (lv[i]) begin
                sb_push(EV_INV, i, 0);
            end
        end
        cpu_req = 0;
        flush_req = 1;
        #1;
        n_vec++;
        if (flush_mode !== 1'b0) begin
            n_err++;
            $display("FAIL flush_start: flush_mode=%b in IDLE, expected 0", flush_mode);
        end
        next_cycle();
        flush_req = 0;
        run_flush(-1, done, clrs);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            pulses += int'(flush_done) + int'(flush_mode);
            next_cycle();
        end
        n_vec++;
        if (pulses != 0 || flush_idx !== '0) begin
            n_err++;
            $display("FAIL flush_after: extra done/mode=%0d flush_idx=%0d, expected 0 0", pulses, flush_idx);
        end
        n_vec++;
        if (clrs != 2) begin
            n_err++;
            $display("FAIL flush_clr_dirty: %0d pulses, expected 2", clrs);
        end
        check_sb_empty("flush_sb");
    endtask

    task automatic test_flush_vs_miss();
        bit done;
        int clrs;
        cpu_req = 1; hit = 0; line_valid = 0; dirty = 0; flush_req = 1;
        for (int b = 0; b < BT; b++) sb_push(EV_RFL, 0, b);
        #1;
        n_vec++;
        if (stall !== 1'b1 || flush_mode !== 1'b0) begin
            n_err++;
            $display("FAIL race_idle: stall=%b flush_mode=%b, expected 1 0", stall, flush_mode);
        end
        exp_miss++;
        next_cycle();
        flush_req = 0;
        mem_ready = 1;
        #1;
        next_cycle();
        mem_ready = 0;
        for (int b = 0; b < BT; b++) begin
            mem_rsp_valid = 1;
            #1;
            next_cycle();
        end
        mem_rsp_valid = 0;
        hit = 1;
        #1;
        n_vec++;
        if (cache_en !== 1'b1 || flush_mode !== 1'b0) begin
            n_err++;
            $display("FAIL race_retry: cache_en=%b flush_mode=%b, expected 1 0", cache_en, flush_mode);
        end
        exp_hit++;
        next_cycle();
        cpu_req = 0; hit = 0;
        #1;
        next_cycle();
        #1;
        n_vec++;
        if (flush_mode !== 1'b1 || flush_idx !== '0) begin
            n_err++;
            $display("FAIL race_flush_start: flush_mode=%b flush_idx=%0d, expected 1 0", flush_mode, flush_idx);
        end
        // A flush_req during the walk must queue a second walk.
        run_flush(3, done, clrs);
        #1;
        n_vec++;
        if (flush_mode !== 1'b0) begin
            n_err++;
            $display("FAIL pending_idle: flush_mode=%b, expected 0", flush_mode);
        end
        next_cycle();
        run_flush(-1, done, clrs);
        check_counters("race_counts");
        check_sb_empty("race_sb");
    endtask

    task automatic test_reset_mid_refill();
        cpu_req = 1; hit = 0; line_valid = 0; dirty = 0;
        sb_push(EV_RFL, 0, 0);
        sb_push(EV_RFL, 0, 1);
        #1;
        next_cycle();
        mem_ready = 1;
        #1;
        next_cycle();
        mem_ready = 0;
        for (int b = 0; b < 2; b++) begin
            mem_rsp_valid = 1;
            #1;
            next_cycle();
        end
        mem_rsp_valid = 0;
        cpu_req = 0;
        rst = 1;
        #1;
        n_vec++;
        if (outs !== '0) begin
            n_err++;
            $display("FAIL reset_async: outs=%h, expected 0", outs);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (outs !== '0 || beat_idx !== '0) begin
            n_err++;
            $display("FAIL reset_held: outs=%h, expected 0", outs);
        end
        rst = 0;
        exp_hit  = 0;
        exp_miss = 0;
        @(posedge clk);
        #1;
        cpu_req = 1; hit = 1;
        #1;
        n_vec++;
        if (cache_en !== 1'b1 || stall !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_hit: cache_en=%b stall=%b, expected 1 0", cache_en, stall);
        end
        exp_hit++;
        next_cycle();
        check_sb_empty("reset_sb");
        test_clean_miss();
    endtask

    task automatic test_saturation();
        int n;
        n = 65535 - exp_hit + 4;
        cpu_req = 1; hit = 1; cpu_we = 0;
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
        cpu_req = 0; hit = 0;
        #1;
        n_vec++;
        if (hit_cnt !== 16'hFFFF || miss_cnt !== CW'(exp_miss)) begin
            n_err++;
            $display("FAIL hit_saturation: hit_cnt=%h miss_cnt=%0d, expected ffff %0d", hit_cnt, miss_cnt, exp_miss);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_hits();
        test_clean_miss();
        test_dirty_miss();
        test_flush();
        test_flush_vs_miss();
        test_reset_mid_refill();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
